cci_mpf_csr_event_ctrs: RTL and testbench
=========================================

CCI_MPF_CSR_EVENT_CTRS -- requirements
Module: cci_mpf_csr_event_ctrs
Role: downstream of MPF CSR event signals; accumulates shim event pulses (VC map changes, WRO pipe events, PWRITE) into MMIO-readable counters.

Interface
REQ-001 SHALL have parameter N_EVENTS, default 8, number of independent event inputs (1..64).
REQ-002 SHALL have parameter CTR_BITS, default 48, counter width (1..62).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port evt_in  input  N_EVENTS  one-cycle event pulses, bit i increments counter i.
REQ-006 SHALL have port rd_req  input  1  counter read request, one per cycle maximum.
REQ-007 SHALL have port rd_idx  input  max(1,$clog2(N_EVENTS))  counter index for rd_req.
REQ-008 SHALL have port rd_tid  input  9  MMIO transaction ID, returned unmodified.
REQ-009 SHALL have port clr_req  input  1  clear counter clr_idx.
REQ-010 SHALL have port clr_idx  input  max(1,$clog2(N_EVENTS))  counter index for clr_req.
REQ-011 SHALL have port clr_all  input  1  clear all counters.
REQ-012 SHALL have port rd_rsp_valid  output  1  read response strobe, one cycle.
REQ-013 SHALL have port rd_rsp_tid  output  9  rd_tid of the matching request.
REQ-014 SHALL have port rd_rsp_data  output  64  [CTR_BITS-1:0] count, [62:CTR_BITS] zero, [63] overflow flag.

Function
REQ-015 Each cycle, counter i SHALL increment by 1 when evt_in[i]=1; no flow control, no event dropped except per REQ-017/REQ-019.
REQ-016 Counters SHALL be independent; simultaneous pulses on all bits SHALL all count in the same cycle.
REQ-017 clr_all, or clr_req with clr_idx=i, SHALL force counter i and its overflow flag to 0 at the ending edge, taking priority over a same-cycle evt_in[i] (event lost).
REQ-018 clr_req with clr_idx>=N_EVENTS SHALL have no effect.
REQ-019 Wrap/saturation at 2^CTR_BITS-1 SHALL follow REQ-029/REQ-030.
REQ-020 Read pipeline: rd_req sampled in cycle N SHALL produce rd_rsp_valid=1 in cycle N+2 exactly; fixed 2-cycle latency.
REQ-021 Response data SHALL equal counter value including all events and clears of cycles <=N.
REQ-022 Back-to-back rd_req every cycle SHALL be accepted; responses in request order, one per cycle.
REQ-023 rd_idx>=N_EVENTS SHALL return rd_rsp_data=0 with valid response and tid.
REQ-024 rd_rsp_tid and rd_rsp_data SHALL be held stable until the next response; rd_rsp_valid=0 otherwise.
REQ-025 Read and clear of same index in cycle N SHALL return 0.

Reset
REQ-026 reset SHALL zero all counters and overflow flags at the ending edge.
REQ-027 reset SHALL force rd_rsp_valid=0, rd_rsp_tid=0, rd_rsp_data=0; reads in flight SHALL be discarded, never returned.
REQ-028 evt_in, rd_req, clr_req, clr_all during reset SHALL be ignored; first accepted inputs in first cycle with reset=0.

Configuration
REQ-029 With MPF_EVENT_CTR_SATURATE_EN defined: counter at 2^CTR_BITS-1 SHALL hold that value on further events and set sticky overflow flag (bit 63) until cleared or reset.
REQ-030 Without MPF_EVENT_CTR_SATURATE_EN: counters SHALL wrap modulo 2^CTR_BITS, no overflow flag storage; bit 63 always 0.

Verification
REQ-031 Reset, then evt_in[3] pulsed 5 cycles, rd_req idx=3 tid=0x15 next cycle -> 2 cycles later rd_rsp_valid=1, tid=0x15, data=5.
REQ-032 evt_in=all-ones 10 cycles, reads idx 0..7 on 8 consecutive cycles -> 8 consecutive responses each data=10, tids in order.
REQ-033 Counter 2=7, same cycle clr_req idx=2, evt_in[2]=1, rd_req idx=2 -> response data=0; next event then read -> 1.
REQ-034 CTR_BITS=4, 20 events on bit 0 -> SATURATE_EN: data=0x8000_0000_0000_000F; without: data=4.
REQ-035 rd_req issued, reset asserted next cycle for 1 cycle -> no rd_rsp_valid; subsequent read idx=0 returns 0.
REQ-036 rd_req idx=9 with N_EVENTS=8 -> rd_rsp_valid=1, data=0; clr_req idx=9 leaves all counters unchanged.

Source files
------------

// File: rtl/cci_mpf_csr_event_ctrs.sv
// MMIO-readable event counters for MPF shim events, 2-cycle read pipeline.
// Define MPF_EVENT_CTR_SATURATE_EN for saturating counters with sticky bit 63.
module cci_mpf_csr_event_ctrs #(
  parameter int N_EVENTS = 8,
  parameter int CTR_BITS = 48,
  localparam int IW = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_EVENTS-1:0] evt_in,
  input  logic                rd_req,
  input  logic [IW-1:0]       rd_idx,
  input  logic [8:0]          rd_tid,
  input  logic                clr_req,
  input  logic [IW-1:0]       clr_idx,
  input  logic                clr_all,
  output logic                rd_rsp_valid,
  output logic [8:0]          rd_rsp_tid,
  output logic [63:0]         rd_rsp_data
);

  logic [CTR_BITS-1:0] ctr [N_EVENTS];
  logic [N_EVENTS-1:0] ovf;
  logic [N_EVENTS-1:0] clr_hit;

  logic          s1_valid;
  logic [IW-1:0] s1_idx;
  logic [8:0]    s1_tid;
  logic [63:0]   rd_word;

  always_comb begin
    clr_hit = '0;
    for (int i = 0; i < N_EVENTS; i++)
      clr_hit[i] = clr_all | (clr_req & (clr_idx == IW'(i)));
  end

`ifdef MPF_EVENT_CTR_SATURATE_EN
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_EVENTS; i++) begin
      if (reset || clr_hit[i])
        ctr[i] <= '0;
      else if (evt_in[i] && (ctr[i] != CTR_MAX))
        ctr[i] <= ctr[i] + CTR_BITS'(1);
    end
  end

  // Sticky until cleared: records any event arriving at full scale
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_EVENTS; i++) begin
      if (reset || clr_hit[i])
        ovf[i] <= 1'b0;
      else if (evt_in[i] && (ctr[i] == CTR_MAX))
        ovf[i] <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_EVENTS; i++) begin
      if (reset || clr_hit[i])
        ctr[i] <= '0;
      else if (evt_in[i])
        ctr[i] <= ctr[i] + CTR_BITS'(1);
    end
  end

  assign ovf = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_tid   <= '0;
    end else begin
      s1_valid <= rd_req;
      s1_idx   <= rd_idx;
      s1_tid   <= rd_tid;
    end
  end

  // Counters already reflect the request cycle; out-of-range reads stay 0
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N_EVENTS; i++) begin
      if (s1_idx == IW'(i)) begin
        rd_word[CTR_BITS-1:0] = ctr[i];
        rd_word[63]           = ovf[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_tid   <= '0;
      rd_rsp_data  <= '0;
    end else begin
      rd_rsp_valid <= s1_valid;
      if (s1_valid) begin
        rd_rsp_tid  <= s1_tid;
        rd_rsp_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_cci_mpf_csr_event_ctrs.sv
// Directed bench for cci_mpf_csr_event_ctrs: default instance plus a
// small one (5 events, 4-bit counters) for wrap/saturation and range checks.
module tb_cci_mpf_csr_event_ctrs;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  evt_in;
  logic        rd_req;
  logic [2:0]  rd_idx;
  logic [8:0]  rd_tid;
  logic        clr_req;
  logic [2:0]  clr_idx;
  logic        clr_all;
  logic        rd_rsp_valid;
  logic [8:0]  rd_rsp_tid;
  logic [63:0] rd_rsp_data;

  logic [4:0]  evt2;
  logic        rd2_req;
  logic [2:0]  rd2_idx;
  logic [8:0]  rd2_tid;
  logic        clr2_req;
  logic [2:0]  clr2_idx;
  logic        clr2_all;
  logic        rsp2_valid;
  logic [8:0]  rsp2_tid;
  logic [63:0] rsp2_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cci_mpf_csr_event_ctrs dut (
    .clk          (clk),
    .reset        (reset),
    .evt_in       (evt_in),
    .rd_req       (rd_req),
    .rd_idx       (rd_idx),
    .rd_tid       (rd_tid),
    .clr_req      (clr_req),
    .clr_idx      (clr_idx),
    .clr_all      (clr_all),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_tid   (rd_rsp_tid),
    .rd_rsp_data  (rd_rsp_data)
  );

  cci_mpf_csr_event_ctrs #(.N_EVENTS(5), .CTR_BITS(4)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .evt_in       (evt2),
    .rd_req       (rd2_req),
    .rd_idx       (rd2_idx),
    .rd_tid       (rd2_tid),
    .clr_req      (clr2_req),
    .clr_idx      (clr2_idx),
    .clr_all      (clr2_all),
    .rd_rsp_valid (rsp2_valid),
    .rd_rsp_tid   (rsp2_tid),
    .rd_rsp_data  (rsp2_data)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] idx, input logic [8:0] tid);
    rd_req = 1'b1; rd_idx = idx; rd_tid = tid;
    tick();
    rd_req = 1'b0;
    tick();
  endtask

  task automatic rd2(input logic [2:0] idx, input logic [8:0] tid);
    rd2_req = 1'b1; rd2_idx = idx; rd2_tid = tid;
    tick();
    rd2_req = 1'b0;
    tick();
  endtask

  task automatic rsp(input string tag, input logic [8:0] tid,
                     input logic [63:0] data);
    check({tag, "_valid"}, {63'd0, rd_rsp_valid}, 64'd1);
    check({tag, "_tid"}, {55'd0, rd_rsp_tid}, {55'd0, tid});
    check({tag, "_data"}, rd_rsp_data, data);
  endtask

  task automatic rsp2(input string tag, input logic [8:0] tid,
                      input logic [63:0] data);
    check({tag, "_valid"}, {63'd0, rsp2_valid}, 64'd1);
    check({tag, "_tid"}, {55'd0, rsp2_tid}, {55'd0, tid});
    check({tag, "_data"}, rsp2_data, data);
  endtask

  initial begin
    logic [63:0] exp_sat;
    reset = 1'b1;
    evt_in = '1; rd_req = 1'b1; rd_idx = 3'd0; rd_tid = 9'h1FF;
    clr_req = 1'b0; clr_idx = '0; clr_all = 1'b0;
    evt2 = '1; rd2_req = 1'b0; rd2_idx = '0; rd2_tid = '0;
    clr2_req = 1'b0; clr2_idx = '0; clr2_all = 1'b0;
    tick(); tick(); tick();
    check("rst_valid", {63'd0, rd_rsp_valid}, 64'd0);
    check("rst_tid", {55'd0, rd_rsp_tid}, 64'd0);
    check("rst_data", rd_rsp_data, 64'd0);
    reset = 1'b0; evt_in = '0; rd_req = 1'b0; evt2 = '0;
    tick();
    check("post_rst_idle", {63'd0, rd_rsp_valid}, 64'd0);
    rd(3'd0, 9'h001);
    rsp("rst_ignored", 9'h001, 64'd0);

    // five pulses on bit 3, then read
    evt_in = 8'h08;
    repeat (5) tick();
    evt_in = '0;
    rd(3'd3, 9'h015);
    rsp("evt3", 9'h015, 64'd5);
    tick();
    check("evt3_drop", {63'd0, rd_rsp_valid}, 64'd0);
    check("evt3_hold_tid", {55'd0, rd_rsp_tid}, 64'h15);
    check("evt3_hold_data", rd_rsp_data, 64'd5);

    // all bits together, back-to-back reads
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    evt_in = '1;
    repeat (10) tick();
    evt_in = '0;
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1; rd_idx = 3'(i); rd_tid = 9'h040 + 9'(i);
      tick();
      if (i >= 1) rsp("b2b", 9'h040 + 9'(i - 1), 64'd10);
    end
    rd_req = 1'b0;
    tick();
    rsp("b2b_last", 9'h047, 64'd10);
    tick();
    check("b2b_end", {63'd0, rd_rsp_valid}, 64'd0);

    // clear beats a same-cycle event and read
    clr_req = 1'b1; clr_idx = 3'd2;
    tick();
    clr_req = 1'b0;
    evt_in = 8'h04;
    repeat (7) tick();
    evt_in = '0;
    rd(3'd2, 9'h032);
    rsp("c2_seven", 9'h032, 64'd7);
    clr_req = 1'b1; clr_idx = 3'd2; evt_in = 8'h04;
    rd_req = 1'b1; rd_idx = 3'd2; rd_tid = 9'h033;
    tick();
    clr_req = 1'b0; evt_in = '0; rd_req = 1'b0;
    tick();
    rsp("clr_rd", 9'h033, 64'd0);
    evt_in = 8'h04;
    tick();
    evt_in = '0;
    rd(3'd2, 9'h034);
    rsp("clr_then_evt", 9'h034, 64'd1);
    rd(3'd3, 9'h035);
    rsp("c3_untouched", 9'h035, 64'd10);

    // narrow instance: 20 events on bit 0, 3 on bit 1
    evt2 = 5'b00011;
    repeat (3) tick();
    evt2 = 5'b00001;
    repeat (17) tick();
    evt2 = '0;
`ifdef MPF_EVENT_CTR_SATURATE_EN
    exp_sat = 64'h8000_0000_0000_000F;
`else
    exp_sat = 64'd4;
`endif
    rd2(3'd0, 9'h0A0);
    rsp2("n_c0", 9'h0A0, exp_sat);
    rd2(3'd6, 9'h1A6);
    rsp2("n_oob", 9'h1A6, 64'd0);
    clr2_req = 1'b1; clr2_idx = 3'd6;
    tick();
    clr2_req = 1'b0;
    rd2(3'd1, 9'h0A1);
    rsp2("n_oob_clr_c1", 9'h0A1, 64'd3);
    rd2(3'd0, 9'h0A2);
    rsp2("n_oob_clr_c0", 9'h0A2, exp_sat);
    clr2_req = 1'b1; clr2_idx = 3'd0;
    tick();
    clr2_req = 1'b0;
    rd2(3'd0, 9'h0A3);
    rsp2("n_clr_c0", 9'h0A3, 64'd0);

    // reset discards an in-flight read
    rd_req = 1'b1; rd_idx = 3'd3; rd_tid = 9'h077;
    tick();
    rd_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("flush_valid", {63'd0, rd_rsp_valid}, 64'd0);
    tick();
    check("flush_valid2", {63'd0, rd_rsp_valid}, 64'd0);
    check("flush_tid", {55'd0, rd_rsp_tid}, 64'd0);
    rd(3'd0, 9'h078);
    rsp("post_flush", 9'h078, 64'd0);
    rd(3'd3, 9'h079);
    rsp("post_flush_c3", 9'h079, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
